// File: rtl/stream_delay_pkg.sv
// Shared types and helpers for the stream_delay latency-balancing line.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   depth_w(max_depth) - width needed to hold a depth value 0..max_depth
//   stage_t            - {valid, data} stage record at the default 16-bit width.
//                        Instances with another WIDTH declare the same shape locally
//                        and hand it to delay_stage through its type parameter.
package stream_delay_pkg;

    localparam int STAGE_DEFAULT_W = 16;

    typedef struct packed {
        logic                       valid;
        logic [STAGE_DEFAULT_W-1:0] data;
    } stage_t;

    function automatic int depth_w(input int max_depth);
        return $clog2(max_depth + 1);
    endfunction

endpackage

// File: rtl/delay_stage.sv
// One {valid, data} register of the stream_delay shift chain.
// Latency: 1 enabled edge from d to q.
// Backpressure: none; en=0 holds the stage, clr_valid clears valid only.
//
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset (clears all)
//   en            - load d into the stage this cycle
//   clr_valid     - clear the valid bit, keep data; wins over en
//   d / q         - stage input / registered stage contents (type T)
module delay_stage
    import stream_delay_pkg::*;
#(
    parameter type T = stage_t
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr_valid,
    input  T     d,
    output T     q
);

    T stage_q;
    T stage_d;

    always_comb begin
        stage_d = stage_q;
        if (clr_valid) begin
            stage_d.valid = 1'b0;
        end else if (en) begin
            stage_d = d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q;

endmodule

// File: rtl/stream_delay.sv
// Stallable, run-time-programmable delay line that balances path latencies between kernels.
// Latency: depth enabled edges from acceptance to visibility on out (tap is stage depth-1, no output reg).
// Backpressure: none; en=0 freezes every stage, flush/cfg_load drop the input of that cycle.
//
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   en, flush             - global advance / clear all valid bits
//   in, in_valid          - input sample
//   depth_cfg, cfg_load   - run-time depth request (accepted only when idle and in 1..MAX_DEPTH)
//   out, out_valid        - sample at tap depth-1
//   busy                  - any valid in stages 0..depth-1
//   cfg_err               - one-cycle pulse after a rejected cfg_load
//   depth                 - active depth
//   count                 - occupancy of stages 0..depth-1 (only with STREAM_DELAY_OCCUPANCY_EN)
module stream_delay
    import stream_delay_pkg::*;
#(
    parameter  int WIDTH         = 16,
    parameter  int MAX_DEPTH     = 32,
    parameter  int DEFAULT_DEPTH = 8,
    localparam int DW            = depth_w(MAX_DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic [DW-1:0]    depth_cfg,
    input  logic             cfg_load,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             cfg_err,
`ifdef STREAM_DELAY_OCCUPANCY_EN
    output logic [DW-1:0]    count,
`endif
    output logic [DW-1:0]    depth
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_w_t;

    localparam logic [DW-1:0] MAX_D     = DW'(MAX_DEPTH);
    localparam logic [DW-1:0] DEFAULT_D = DW'(DEFAULT_DEPTH);
    localparam logic [DW-1:0] ONE_D     = DW'(1);

    if (DEFAULT_DEPTH < 1 || DEFAULT_DEPTH > MAX_DEPTH) begin : g_bad_default
        $error("stream_delay: DEFAULT_DEPTH must be in 1..MAX_DEPTH");
    end

    stage_w_t        stg [MAX_DEPTH];
    stage_w_t        tap;
    logic [DW-1:0]   tap_idx;
    logic [DW-1:0]   depth_q;
    logic [DW-1:0]   depth_d;
    logic            cfg_err_q;
    logic            cfg_err_d;
    logic            cfg_ok;
    logic            cfg_accept;
    logic            cfg_reject;
    logic            clr_all;
    logic            shift_en;

    // Control decode. Flush outranks cfg_load (which is then silently ignored);
    // an accepted load clears every stage so bits beyond the old tap cannot resurface.
    always_comb begin
        cfg_ok     = (depth_cfg != '0) && (depth_cfg <= MAX_D);
        cfg_accept = cfg_load && !flush && !busy && cfg_ok;
        cfg_reject = cfg_load && !flush && !cfg_accept;
        clr_all    = flush || cfg_accept;
        shift_en   = en && !clr_all;
    end

    for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage
        stage_w_t d_k;
        if (k == 0) begin : g_head
            assign d_k = {in_valid, in};
        end else begin : g_body
            assign d_k = stg[k-1];
        end
        delay_stage #(
            .T (stage_w_t)
        ) u_stage (
            .clock     (clock),
            .reset     (reset),
            .en        (shift_en),
            .clr_valid (clr_all),
            .d         (d_k),
            .q         (stg[k])
        );
    end

    // Tap mux and busy reduction over the active window 0..depth-1.
    always_comb begin
        tap     = '0;
        busy    = 1'b0;
        tap_idx = depth_q - ONE_D;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            if (DW'(k) == tap_idx) begin
                tap = stg[k];
            end
            if (DW'(k) < depth_q) begin
                busy = busy | stg[k].valid;
            end
        end
    end

    always_comb begin
        depth_d   = depth_q;
        cfg_err_d = cfg_reject;
        if (cfg_accept) begin
            depth_d = depth_cfg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            depth_q   <= DEFAULT_D;
            cfg_err_q <= 1'b0;
        end else begin
            depth_q   <= depth_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign out       = tap.data;
    assign out_valid = tap.valid;
    assign depth     = depth_q;
    assign cfg_err   = cfg_err_q;

`ifdef STREAM_DELAY_OCCUPANCY_EN
    logic [DW-1:0] count_q;
    logic [DW-1:0] count_d;
    logic [DW-1:0] pop_cnt;

    // The sample leaving the window on a shift is the one currently at the tap.
    always_comb begin
        count_d = count_q;
        if (clr_all) begin
            count_d = '0;
        end else if (shift_en) begin
            case ({in_valid, tap.valid})
                2'b10:   count_d = count_q + ONE_D;
                2'b01:   count_d = count_q - ONE_D;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        pop_cnt = '0;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            if ((DW'(k) < depth_q) && stg[k].valid) begin
                pop_cnt = pop_cnt + ONE_D;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (count_q == pop_cnt);
        end
    end

    assign count = count_q;
`endif

endmodule

// File: tb/tb_stream_delay.sv
// Directed self-checking bench for stream_delay (default parameters: WIDTH 16, MAX_DEPTH 32, DEFAULT_DEPTH 8).
// Latency: n/a.
// Backpressure: n/a.
module tb_stream_delay;

    localparam int DW = 6;

    logic          clock;
    logic          reset;
    logic          en;
    logic          flush;
    logic [15:0]   din;
    logic          in_valid;
    logic [DW-1:0] depth_cfg;
    logic          cfg_load;
    logic [15:0]   dout;
    logic          out_valid;
    logic          busy;
    logic          cfg_err;
    logic [DW-1:0] depth;
`ifdef STREAM_DELAY_OCCUPANCY_EN
    logic [DW-1:0] count;
`endif

    int total;
    int bad;

    stream_delay u_dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .in        (din),
        .in_valid  (in_valid),
        .depth_cfg (depth_cfg),
        .cfg_load  (cfg_load),
        .out       (dout),
        .out_valid (out_valid),
        .busy      (busy),
        .cfg_err   (cfg_err),
`ifdef STREAM_DELAY_OCCUPANCY_EN
        .count     (count),
`endif
        .depth     (depth)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it before sampling/driving.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Stream 1..nsamp at depth 8, optionally freezing en for stall_len cycles.
    // Sample k is accepted on enabled edge k and is visible after enabled edge k+7.
    task automatic run_stream(input int nsamp, input int stall_at, input int stall_len);
        int e      = 0;
        int pushed = 0;
        int ncyc   = nsamp + stall_len + 9;
        for (int c = 0; c < ncyc; c++) begin
            en       = !(c >= stall_at && c < stall_at + stall_len);
            in_valid = en && (pushed < nsamp);
            din      = 16'(pushed + 1);
            tick();
            if (en) begin
                e++;
                if (in_valid) pushed++;
            end
            if (e >= 8 && e - 7 <= nsamp) begin
                chk_eq("stream_vld", {31'd0, out_valid}, 32'd1);
                chk_eq("stream_dat", {16'd0, dout}, 32'(e - 7));
            end else begin
                chk_eq("stream_vld", {31'd0, out_valid}, 32'd0);
            end
        end
        en       = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic load_depth(input logic [DW-1:0] d);
        cfg_load  = 1'b1;
        depth_cfg = d;
        tick();
        cfg_load  = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        en        = 1'b0;
        flush     = 1'b0;
        din       = '0;
        in_valid  = 1'b0;
        depth_cfg = '0;
        cfg_load  = 1'b0;

        // Reset state
        tick();
        tick();
        chk_eq("rst_out", {16'd0, dout}, 32'd0);
        chk_eq("rst_vld", {31'd0, out_valid}, 32'd0);
        chk_eq("rst_busy", {31'd0, busy}, 32'd0);
        chk_eq("rst_cfgerr", {31'd0, cfg_err}, 32'd0);
        chk_eq("rst_depth", {26'd0, depth}, 32'd8);
`ifdef STREAM_DELAY_OCCUPANCY_EN
        chk_eq("rst_count", {26'd0, count}, 32'd0);
`endif
        reset = 1'b0;

        // Continuous stream of 20 samples, then drain
        run_stream(20, 1000, 0);
        chk_eq("drain_busy", {31'd0, busy}, 32'd0);

        // Same kind of stream with a 3-cycle stall while the output is valid
        run_stream(12, 10, 3);
        chk_eq("stall_busy", {31'd0, busy}, 32'd0);

        // Depth 1; the input offered in the load cycle must be dropped
        en       = 1'b1;
        in_valid = 1'b1;
        din      = 16'h5555;
        load_depth(6'd1);
        chk_eq("d1_depth", {26'd0, depth}, 32'd1);
        chk_eq("d1_cfgerr", {31'd0, cfg_err}, 32'd0);
        chk_eq("d1_drop_vld", {31'd0, out_valid}, 32'd0);
        din = 16'hABCD;
        tick();
        chk_eq("d1_vld", {31'd0, out_valid}, 32'd1);
        chk_eq("d1_dat", {16'd0, dout}, 32'hABCD);
        in_valid = 1'b0;
        tick();
        chk_eq("d1_gone", {31'd0, out_valid}, 32'd0);

        // Depth MAX_DEPTH: latency 32 enabled edges, then discarded off the end
        load_depth(6'd32);
        chk_eq("d32_depth", {26'd0, depth}, 32'd32);
        for (int j = 0; j <= 32; j++) begin
            in_valid = (j == 0);
            din      = 16'h1234;
            tick();
            chk_eq("d32_vld", {31'd0, out_valid}, {31'd0, (j == 31)});
            if (j == 31) chk_eq("d32_dat", {16'd0, dout}, 32'h1234);
        end
        in_valid = 1'b0;
        chk_eq("d32_busy", {31'd0, busy}, 32'd0);

        // Rejected loads: busy, zero, over range
        load_depth(6'd8);
        chk_eq("d8_depth", {26'd0, depth}, 32'd8);
        in_valid = 1'b1;
        din      = 16'h0F0F;
        tick();
        in_valid = 1'b0;
        en       = 1'b0;
        chk_eq("rej_busy_set", {31'd0, busy}, 32'd1);
        load_depth(6'd4);
        chk_eq("rej_busy_err", {31'd0, cfg_err}, 32'd1);
        chk_eq("rej_busy_depth", {26'd0, depth}, 32'd8);
        tick();
        chk_eq("rej_busy_pulse", {31'd0, cfg_err}, 32'd0);
        load_depth(6'd0);
        chk_eq("rej_zero_err", {31'd0, cfg_err}, 32'd1);
        chk_eq("rej_zero_depth", {26'd0, depth}, 32'd8);
        tick();
        chk_eq("rej_zero_pulse", {31'd0, cfg_err}, 32'd0);
        load_depth(6'd33);
        chk_eq("rej_big_err", {31'd0, cfg_err}, 32'd1);
        chk_eq("rej_big_depth", {26'd0, depth}, 32'd8);
        tick();
        chk_eq("rej_big_pulse", {31'd0, cfg_err}, 32'd0);

        // Flush with 5 samples in flight; the sample offered with the flush is dropped
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_eq("pre_flush_busy", {31'd0, busy}, 32'd0);
        en = 1'b1;
        for (int j = 0; j < 5; j++) begin
            in_valid = 1'b1;
            din      = 16'(16'h0100 + j);
            tick();
        end
        chk_eq("fl_busy_before", {31'd0, busy}, 32'd1);
`ifdef STREAM_DELAY_OCCUPANCY_EN
        chk_eq("fl_count_before", {26'd0, count}, 32'd5);
`endif
        flush    = 1'b1;
        din      = 16'h7777;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_eq("fl_busy_after", {31'd0, busy}, 32'd0);
`ifdef STREAM_DELAY_OCCUPANCY_EN
        chk_eq("fl_count_after", {26'd0, count}, 32'd0);
`endif
        for (int j = 0; j < 8; j++) begin
            tick();
            chk_eq("fl_out_vld", {31'd0, out_valid}, 32'd0);
        end

        // Reset mid-stream at depth 3 with 4 samples pushed
        load_depth(6'd3);
        chk_eq("d3_depth", {26'd0, depth}, 32'd3);
        for (int j = 1; j <= 4; j++) begin
            in_valid = 1'b1;
            din      = 16'(j * 16'h11);
            tick();
        end
        chk_eq("d3_vld", {31'd0, out_valid}, 32'd1);
        chk_eq("d3_dat", {16'd0, dout}, 32'h22);
`ifdef STREAM_DELAY_OCCUPANCY_EN
        chk_eq("d3_count", {26'd0, count}, 32'd3);
`endif
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk_eq("mrst_out", {16'd0, dout}, 32'd0);
        chk_eq("mrst_vld", {31'd0, out_valid}, 32'd0);
        chk_eq("mrst_depth", {26'd0, depth}, 32'd8);
        chk_eq("mrst_busy", {31'd0, busy}, 32'd0);
        chk_eq("mrst_cfgerr", {31'd0, cfg_err}, 32'd0);
`ifdef STREAM_DELAY_OCCUPANCY_EN
        chk_eq("mrst_count", {26'd0, count}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
